// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader: re-serialises buffered {packet_length, interface_id} + payload word records
// into 8-bit AXI-Stream frames and drops out-of-range records. Optional macro: STRIP_FCS_EN.
module packet_buffer_reader #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_word_tdata,
  input  logic             s_word_tvalid,
  output logic             s_word_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [15:0]      m_axis_tuser,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_EMIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       rem_q, rem_d;
  logic [15:0]      bytes_left_q, bytes_left_d;
  logic [15:0]      words_left_q, words_left_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [15:0]      tuser_q, tuser_d;
  logic             drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             busy_q, busy_d;

  logic [15:0]      hdr_len_s, hdr_iface_s, hdr_words_s, emit_len_s, bl_m1_s;
  logic             len_ok_s, out_free_s, tready_s, word_hs_s, load_s;

  // Header field decode and output-stage availability
  always_comb begin
    hdr_len_s   = s_word_tdata[31:16];
    hdr_iface_s = s_word_tdata[15:0];
    hdr_words_s = 16'((17'(hdr_len_s) + 17'd3) >> 2);
    len_ok_s    = (hdr_len_s >= 16'(MIN_LEN)) && (hdr_len_s <= 16'(MAX_LEN));
`ifdef STRIP_FCS_EN
    emit_len_s  = hdr_len_s - 16'd4;
`else
    emit_len_s  = hdr_len_s;
`endif
    bl_m1_s     = bytes_left_q - 16'd1;
    out_free_s  = !tvalid_q || m_axis_tready;
  end

  // Word-side ready: in EMIT a word is taken only once the holding register has handed off its last byte
  always_comb begin
    tready_s = 1'b0;
    case (state_q)
      ST_HDR:  tready_s = 1'b1;
      ST_EMIT: tready_s = (rem_q == 2'd0) && (words_left_q != 16'd0) &&
                          ((bytes_left_q == 16'd0) || out_free_s);
      ST_DROP: tready_s = 1'b1;
      default: tready_s = 1'b0;
    endcase
    word_hs_s = s_word_tvalid && tready_s && !rst;
  end

  // Next-state and output-stage logic
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    rem_d        = rem_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;
    load_s       = 1'b0;

    case (state_q)
      ST_HDR: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (word_hs_s) begin
          words_left_d = hdr_words_s;
          rem_d        = 2'd0;
          if (len_ok_s) begin
            state_d      = ST_EMIT;
            bytes_left_d = emit_len_s;
            tuser_d      = hdr_iface_s;
          end else begin
            drop_pulse_d = 1'b1;
            bytes_left_d = 16'd0;
            if (drop_count_q != {CNT_W{1'b1}}) begin
              drop_count_d = drop_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              drop_count_d = drop_count_q;
            end
            state_d = (hdr_words_s != 16'd0) ? ST_DROP : ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_EMIT: begin
        if (out_free_s) begin
          if (rem_q != 2'd0) begin
            load_s  = 1'b1;
            tdata_d = word_q[31:24];
            word_d  = {word_q[23:0], 8'd0};
            rem_d   = rem_q - 2'd1;
          end else if (word_hs_s && (bytes_left_q != 16'd0)) begin
            load_s  = 1'b1;
            tdata_d = s_word_tdata[31:24];
            word_d  = {s_word_tdata[23:0], 8'd0};
            // Bytes past the frame end (pad or stripped FCS) never enter the shift count
            rem_d   = (bl_m1_s >= 16'd3) ? 2'd3 : bl_m1_s[1:0];
          end else begin
            load_s  = 1'b0;
          end
          tvalid_d = load_s;
          tlast_d  = load_s && (bytes_left_q == 16'd1);
          if (load_s) begin
            bytes_left_d = bl_m1_s;
          end else begin
            bytes_left_d = bytes_left_q;
          end
        end else begin
          tvalid_d = tvalid_q;
        end

        if (word_hs_s) begin
          words_left_d = words_left_q - 16'd1;
        end else begin
          words_left_d = words_left_q;
        end

        if ((words_left_d == 16'd0) && (bytes_left_d == 16'd0) && !tvalid_d) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_DROP: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (word_hs_s) begin
          words_left_d = words_left_q - 16'd1;
          state_d      = (words_left_q == 16'd1) ? ST_HDR : ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d  = ST_HDR;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_HDR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HDR;
      word_q       <= 32'd0;
      rem_q        <= 2'd0;
      bytes_left_q <= 16'd0;
      words_left_q <= 16'd0;
      tdata_q      <= 8'd0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 16'd0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      rem_q        <= rem_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
      busy_q       <= busy_d;
    end
  end

  assign s_word_tready = tready_s && !rst;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign drop_pulse    = drop_pulse_q;
  assign drop_count    = drop_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Bench for packet_buffer_reader: queue-based record model, randomized handshakes and directed scenarios.
module tb_packet_buffer_reader;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int BUDGET  = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_word_tdata;
  logic        s_word_tvalid;
  logic        s_word_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tuser;
  logic        drop_pulse;
  logic [31:0] drop_count;
  logic        busy;

  always #5 clk = ~clk;

  packet_buffer_reader #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_word_tdata(s_word_tdata), .s_word_tvalid(s_word_tvalid), .s_word_tready(s_word_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];
  logic [24:0] eq[$];
  int exp_drops = 0;
  int exp_pulses = 0;
  int pulses = 0;
  int first_hs, last_hs, pay_cyc;

  always @(negedge clk) if (drop_pulse === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int out_len_of(input int len);
`ifdef STRIP_FCS_EN
    return len - 4;
`else
    return len;
`endif
  endfunction

  // Model: build the word stream and the expected byte stream for one record
  task automatic add_record(input int len, input logic [15:0] iface, input bit incr);
    int nwords;
    int olen;
    logic [7:0] b[];
    nwords = (len + 3) / 4;
    b = new[nwords * 4];
    for (int i = 0; i < nwords * 4; i++) b[i] = incr ? 8'(i) : 8'($urandom);
    wq.push_back({16'(len), iface});
    for (int w = 0; w < nwords; w++) wq.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
    if (len >= MIN_LEN && len <= MAX_LEN) begin
      olen = out_len_of(len);
      for (int i = 0; i < olen; i++) eq.push_back({(i == olen - 1), iface, b[i]});
    end else begin
      exp_drops++;
      exp_pulses++;
    end
  endtask

  // Drive all queued words and check every output byte against the model
  task automatic run_batch(input int gap_pct, input int rdy_pct);
    int wi = 0;
    int cyc = 0;
    bit acc = 1'b0;
    bit stall = 1'b0;
    logic [24:0] held = '0;
    logic [24:0] exp;
    first_hs = -1; last_hs = -1; pay_cyc = -1;
    while ((wi < wq.size() || eq.size() != 0) && cyc < BUDGET) begin
      @(posedge clk); #1;
      if (!(s_word_tvalid && !acc)) begin
        if (wi < wq.size() && $urandom_range(99) >= gap_pct) begin
          s_word_tvalid = 1'b1;
          s_word_tdata  = wq[wi];
        end else begin
          s_word_tvalid = 1'b0;
          s_word_tdata  = $urandom;
        end
      end
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cyc++;
      acc = s_word_tvalid && s_word_tready;
      if (acc) begin
        if (wi == 1) pay_cyc = cyc;
        wi++;
      end
      if (stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_data", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("byte_expected", 32'(eq.size() != 0), 1);
        if (eq.size() != 0) begin
          exp = eq.pop_front();
          check("byte", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end
    check("batch_in_budget", 32'(cyc < BUDGET), 1);
    @(posedge clk); #1;
    s_word_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("idle_tvalid", m_axis_tvalid, 0);
    check("idle_busy", busy, 0);
    wq.delete();
    eq.delete();
  endtask

  initial begin
    int nb, wi, cyc, len;
    logic [24:0] exp;
    rst = 1'b1;
    s_word_tvalid = 1'b0;
    s_word_tdata  = 32'd0;
    m_axis_tready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tready", s_word_tready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("hdr_tready", s_word_tready, 1);

    // 1: 64-byte incrementing frame, full rate
    add_record(64, 16'h0003, 1'b1);
    run_batch(0, 100);
    check("first_byte_latency", 32'(first_hs - pay_cyc), 1);
    check("throughput", 32'(last_hs - first_hs), 32'(out_len_of(64) - 1));

    // 2: len 65 then a valid header parsed straight after
    add_record(65, 16'h1234, 1'b1);
    add_record(64, 16'h0042, 1'b0);
    run_batch(0, 100);

    // 3: short record dropped, following record intact
    add_record(20, 16'h0007, 1'b0);
    add_record(64, 16'h0008, 1'b0);
    run_batch(10, 80);
    check("drop_count_short", drop_count, 32'(exp_drops));
    check("drop_pulses_short", 32'(pulses), 32'(exp_pulses));

    // 4: length boundaries
    add_record(1519, 16'h0009, 1'b0);
    add_record(0, 16'h000A, 1'b0);
    add_record(1518, 16'h000B, 1'b0);
    add_record(64, 16'h000C, 1'b1);
    run_batch(0, 100);
    check("drop_count_bounds", drop_count, 32'(exp_drops));
    check("drop_pulses_bounds", 32'(pulses), 32'(exp_pulses));

    // 5: random records with random stalls and gaps
    for (int r = 0; r < 100; r++) begin
      int sel;
      sel = $urandom_range(99);
      if (sel < 6)       len = $urandom_range(0, MIN_LEN - 1);
      else if (sel < 8)  len = $urandom_range(MAX_LEN + 1, MAX_LEN + 40);
      else if (sel < 10) len = (sel == 8) ? MIN_LEN : MAX_LEN;
      else               len = $urandom_range(MIN_LEN, 160);
      add_record(len, 16'($urandom), 1'b0);
    end
    run_batch(25, 50);
    check("drop_count_random", drop_count, 32'(exp_drops));
    check("drop_pulses_random", 32'(pulses), 32'(exp_pulses));

    // 6: reset mid-frame after 30 bytes
    add_record(64, 16'h00AA, 1'b1);
    nb = 0; wi = 0; cyc = 0;
    m_axis_tready = 1'b1;
    while (nb < 30 && cyc < 500) begin
      @(posedge clk); #1;
      s_word_tvalid = (wi < wq.size());
      s_word_tdata  = (wi < wq.size()) ? wq[wi] : 32'd0;
      @(negedge clk);
      cyc++;
      if (s_word_tvalid && s_word_tready) wi++;
      if (m_axis_tvalid) begin
        exp = eq.pop_front();
        check("pre_reset_byte", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp);
        nb++;
      end
    end
    check("pre_reset_in_budget", 32'(nb), 30);
    @(posedge clk); #1;
    rst = 1'b1;
    s_word_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_tready", s_word_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs",
          {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser, drop_pulse, busy}, 0);
    check("post_rst_drop_count", drop_count, 0);
    wq.delete();
    eq.delete();
    exp_drops = 0;
    add_record(10, 16'h00BB, 1'b0);
    add_record(70, 16'h00CC, 1'b0);
    run_batch(10, 70);
    check("post_rst_drop_count2", drop_count, 32'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
